// File: rtl/motor_channel_bank.sv
// rtl/motor_channel_bank.sv - bank of motor channels with staggered amp power-up and filtered fault trip
module motor_channel_bank #(
   parameter int          NUM_CHAN      = 4,
   parameter bit          STAGGER       = 1'b1,
   parameter logic [7:0]  DEFAULT_DELAY = 8'd120,
   parameter logic [15:0] DEFAULT_LIM   = 16'h8418,
   parameter int          FAULT_FILT    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     delay_tick,
   input  logic [15:0]              reg_waddr,
   input  logic [31:0]              reg_wdata,
   input  logic                     reg_wen,
   input  logic                     ioexp_present,
   input  logic                     pwr_enable,
   input  logic                     pwr_enable_cmd,
   input  logic                     mv_amp_disable,
   input  logic                     wdog_timeout,
   input  logic [NUM_CHAN-1:0]      amp_fault,
   input  logic [NUM_CHAN-1:0]      safety_trip,
   output logic [16*NUM_CHAN-1:0]   cur_cmd,
   output logic [4*NUM_CHAN-1:0]    ctrl_mode,
   output logic [NUM_CHAN-1:0]      cur_ctrl,
   output logic [16*NUM_CHAN-1:0]   cur_lim,
   output logic [NUM_CHAN-1:0]      safety_en,
   output logic [NUM_CHAN-1:0]      clr_safety,
   output logic [NUM_CHAN-1:0]      amp_enable_cmd,
   output logic [NUM_CHAN-1:0]      amp_disable_pin,
   output logic [NUM_CHAN-1:0]      amp_disable_f,
   output logic [32*NUM_CHAN-1:0]   motor_status,
   output logic [32*NUM_CHAN-1:0]   motor_config
);

   localparam logic [3:0] ADDR_MAIN        = 4'h0;
   localparam logic [3:0] OFF_DAC_CTRL     = 4'h1;
   localparam logic [3:0] OFF_MOTOR_CONFIG = 4'hC;
   localparam logic [7:0] FILT_LAST        = 8'(FAULT_FILT - 1);

   typedef enum logic [1:0] {S_OFF = 2'd0, S_WAIT = 2'd1, S_RAMP = 2'd2, S_ON = 2'd3} seq_state_t;

   logic [15:0]   cmd_q      [NUM_CHAN];
   logic [3:0]    mode_q     [NUM_CHAN];
   logic [7:0]    delay_q    [NUM_CHAN];
   logic [15:0]   lim_q      [NUM_CHAN];
   logic [7:0]    filt_q     [NUM_CHAN];
   logic [7:0]    tick_q     [NUM_CHAN];
   logic [7:0]    tick_d     [NUM_CHAN];
   seq_state_t    state_q    [NUM_CHAN];
   seq_state_t    state_d    [NUM_CHAN];
   logic [NUM_CHAN-1:0] reg_disable, disable_safety, force_disable_f, fault_lat;
   logic [NUM_CHAN-1:0] dac_wen, cfg_wen, sdis, amp_dis, grant;
   logic                any_ramp, granted;
   logic                mode_ok;

   assign mode_ok = (reg_wdata[27:24] == 4'd0) || ((reg_wdata[27:24] == 4'd1) && ioexp_present);

   always_comb begin
      dac_wen = '0;
      cfg_wen = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         dac_wen[i] = reg_wen && (reg_waddr == {ADDR_MAIN, 4'd0, 4'(i + 1), OFF_DAC_CTRL});
         cfg_wen[i] = reg_wen && (reg_waddr == {ADDR_MAIN, 4'd0, 4'(i + 1), OFF_MOTOR_CONFIG});
      end
   end

   assign amp_enable_cmd = dac_wen & {NUM_CHAN{reg_wdata[29] & reg_wdata[28]}};
   assign clr_safety     = {NUM_CHAN{pwr_enable_cmd}} | amp_enable_cmd;
   assign sdis           = {NUM_CHAN{wdog_timeout}} | safety_trip | fault_lat;
   assign amp_dis        = reg_disable | {NUM_CHAN{mv_amp_disable}};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            cmd_q[i]   <= 16'h8000;
            mode_q[i]  <= 4'd0;
            delay_q[i] <= DEFAULT_DELAY;
            lim_q[i]   <= DEFAULT_LIM;
            filt_q[i]  <= 8'd0;
         end
         reg_disable     <= '1;
         disable_safety  <= '0;
         force_disable_f <= '0;
         fault_lat       <= '0;
      end else begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            if (dac_wen[i]) begin
               if (reg_wdata[31] && mode_ok) begin
                  cmd_q[i]  <= reg_wdata[15:0];
                  mode_q[i] <= reg_wdata[27:24];
               end
               reg_disable[i] <= ~pwr_enable | sdis[i] |
                                 (reg_wdata[29] ? ~reg_wdata[28] : reg_disable[i]);
            end else begin
               if (cfg_wen[i]) begin
                  disable_safety[i]  <= reg_wdata[31];
                  force_disable_f[i] <= reg_wdata[30];
                  delay_q[i]         <= reg_wdata[23:16];
                  lim_q[i]           <= reg_wdata[15:0];
               end
               reg_disable[i] <= reg_disable[i] | sdis[i];
            end
            // Fault must persist FAULT_FILT consecutive enabled cycles before it latches
            if (clr_safety[i]) begin
               fault_lat[i] <= 1'b0;
               filt_q[i]    <= 8'd0;
            end else if (!amp_dis[i] && !amp_fault[i]) begin
               if (filt_q[i] == FILT_LAST) fault_lat[i] <= 1'b1;
               else                        filt_q[i]    <= filt_q[i] + 8'd1;
            end else begin
               filt_q[i] <= 8'd0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            state_q[i] <= S_OFF;
            tick_q[i]  <= 8'd0;
         end
      end else begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            state_q[i] <= state_d[i];
            tick_q[i]  <= tick_d[i];
         end
      end
   end

   always_comb begin
      grant    = '0;
      granted  = 1'b0;
      any_ramp = 1'b0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         if (state_q[i] == S_RAMP) any_ramp = 1'b1;
      end
      // Lowest-index waiting channel wins the single ramp slot
      for (int i = 0; i < NUM_CHAN; i++) begin
         if (state_q[i] == S_WAIT && !amp_dis[i]) begin
            if (!STAGGER) begin
               grant[i] = 1'b1;
            end else if (!any_ramp && !granted) begin
               grant[i] = 1'b1;
               granted  = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_CHAN; i++) begin
         state_d[i] = state_q[i];
         tick_d[i]  = tick_q[i];
         if (amp_dis[i]) begin
            state_d[i] = S_OFF;
         end else begin
            case (state_q[i])
               S_OFF:  state_d[i] = ioexp_present ? S_WAIT : S_ON;
               S_WAIT: if (grant[i]) begin
                          state_d[i] = S_RAMP;
                          tick_d[i]  = 8'd0;
                       end
               S_RAMP: if (tick_q[i] == delay_q[i]) begin
                          state_d[i] = S_ON;
                       end else if (delay_tick) begin
                          tick_d[i] = tick_q[i] + 8'd1;
                          if (tick_d[i] == delay_q[i]) state_d[i] = S_ON;
                       end
               default: state_d[i] = S_ON;
            endcase
         end
      end
   end

   always_comb begin
      cur_cmd         = '0;
      ctrl_mode       = '0;
      cur_ctrl        = '0;
      cur_lim         = '0;
      safety_en       = '0;
      amp_disable_pin = '0;
      amp_disable_f   = '0;
      motor_status    = '0;
      motor_config    = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         cur_cmd[16*i +: 16]  = cmd_q[i];
         ctrl_mode[4*i +: 4]  = mode_q[i];
         cur_ctrl[i]          = ~(ioexp_present & (mode_q[i] == 4'd1));
         cur_lim[16*i +: 16]  = lim_q[i];
         safety_en[i]         = ~disable_safety[i] & cur_ctrl[i];
         amp_disable_pin[i]   = amp_dis[i] | (ioexp_present & (state_q[i] != S_ON));
         amp_disable_f[i]     = ~force_disable_f[i] & amp_dis[i];
         motor_status[32*i +: 32] = {fault_lat[i], 1'b0, amp_fault[i], ~reg_disable[i],
                                     mode_q[i], state_q[i], 1'b0, cur_ctrl[i], 2'b00,
                                     safety_trip[i], ~(amp_dis[i] | amp_fault[i]), cmd_q[i]};
         motor_config[32*i +: 32] = {disable_safety[i], force_disable_f[i], 4'd0, ioexp_present,
                                     1'b1, delay_q[i], lim_q[i]};
      end
   end

endmodule

// File: tb/tb_motor_channel_bank.sv
// tb/tb_motor_channel_bank.sv - directed self-checking bench for motor_channel_bank
module tb_motor_channel_bank;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        delay_tick = 1'b0;
   logic [15:0] reg_waddr = '0;
   logic [31:0] reg_wdata = '0;
   logic        reg_wen = 1'b0;
   logic        ioexp_present = 1'b1;
   logic        pwr_enable = 1'b0;
   logic        pwr_enable_cmd = 1'b0;
   logic        mv_amp_disable = 1'b0;
   logic        wdog_timeout = 1'b0;
   logic [3:0]  amp_fault = 4'hF;
   logic [3:0]  safety_trip = 4'h0;
   logic [63:0] cur_cmd;
   logic [15:0] ctrl_mode;
   logic [3:0]  cur_ctrl;
   logic [63:0] cur_lim;
   logic [3:0]  safety_en;
   logic [3:0]  clr_safety;
   logic [3:0]  amp_enable_cmd;
   logic [3:0]  amp_disable_pin;
   logic [3:0]  amp_disable_f;
   logic [127:0] motor_status;
   logic [127:0] motor_config;

   int compared = 0;
   int mismatched = 0;

   motor_channel_bank dut (
      .clk(clk), .reset(reset), .delay_tick(delay_tick),
      .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
      .ioexp_present(ioexp_present), .pwr_enable(pwr_enable), .pwr_enable_cmd(pwr_enable_cmd),
      .mv_amp_disable(mv_amp_disable), .wdog_timeout(wdog_timeout),
      .amp_fault(amp_fault), .safety_trip(safety_trip),
      .cur_cmd(cur_cmd), .ctrl_mode(ctrl_mode), .cur_ctrl(cur_ctrl), .cur_lim(cur_lim),
      .safety_en(safety_en), .clr_safety(clr_safety), .amp_enable_cmd(amp_enable_cmd),
      .amp_disable_pin(amp_disable_pin), .amp_disable_f(amp_disable_f),
      .motor_status(motor_status), .motor_config(motor_config)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] stat(input int ch);
      return motor_status[32*ch +: 32];
   endfunction

   function automatic logic [1:0] st(input int ch);
      logic [31:0] w;
      w = motor_status[32*ch +: 32];
      return w[23:22];
   endfunction

   function automatic logic [15:0] dac_a(input int ch);
      return {8'h00, 4'(ch), 4'h1};
   endfunction

   function automatic logic [15:0] cfg_a(input int ch);
      return {8'h00, 4'(ch), 4'hC};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      reg_waddr = a;
      reg_wdata = d;
      reg_wen = 1'b1;
      step();
      reg_wen = 1'b0;
   endtask

   task automatic tick();
      delay_tick = 1'b1;
      step();
      delay_tick = 1'b0;
   endtask

   task automatic en_pair();
      reg_waddr = dac_a(1);
      reg_wdata = 32'h3000_0000;
      reg_wen = 1'b1;
      step();
      reg_waddr = dac_a(2);
      step();
      reg_wen = 1'b0;
   endtask

   task automatic test_reset();
      ioexp_present = 1'b1;
      pwr_enable = 1'b0;
      amp_fault = 4'hF;
      do_reset();
      step();
      compared++;
      if (amp_disable_pin !== 4'hF) begin mismatched++; $display("FAIL reset_pin: got %h want f", amp_disable_pin); end
      compared++;
      if (amp_disable_f !== 4'hF) begin mismatched++; $display("FAIL reset_dis_f: got %h want f", amp_disable_f); end
      compared++;
      if (cur_cmd !== {4{16'h8000}}) begin mismatched++; $display("FAIL reset_cmd: got %h want 8000x4", cur_cmd); end
      compared++;
      if (motor_config[31:0] !== 32'h0378_8418) begin mismatched++; $display("FAIL reset_config: got %h want 03788418", motor_config[31:0]); end
      compared++;
      if (stat(0) !== 32'h2010_8000) begin mismatched++; $display("FAIL reset_status: got %h want 20108000", stat(0)); end
      compared++;
      if (safety_en !== 4'hF) begin mismatched++; $display("FAIL reset_safety_en: got %h want f", safety_en); end
   endtask

   task automatic test_enable_delay();
      do_reset();
      pwr_enable = 1'b1;
      wr(cfg_a(1), 32'h0003_8418);
      compared++;
      if (motor_config[31:0] !== 32'h0303_8418) begin mismatched++; $display("FAIL cfg_write: got %h want 03038418", motor_config[31:0]); end
      reg_waddr = dac_a(1);
      reg_wdata = 32'h3000_0000;
      reg_wen = 1'b1;
      #1;
      compared++;
      if (amp_enable_cmd !== 4'b0001) begin mismatched++; $display("FAIL en_cmd: got %b want 0001", amp_enable_cmd); end
      compared++;
      if (clr_safety !== 4'b0001) begin mismatched++; $display("FAIL clr_safety: got %b want 0001", clr_safety); end
      @(posedge clk);
      #1;
      reg_wen = 1'b0;
      compared++;
      if (stat(0)[28] !== 1'b1 || st(0) !== 2'd0) begin mismatched++; $display("FAIL en_cycle0: got %h want en=1 state=0", stat(0)); end
      step();
      compared++;
      if (st(0) !== 2'd1) begin mismatched++; $display("FAIL en_wait: got %0d want 1", st(0)); end
      step();
      compared++;
      if (st(0) !== 2'd2) begin mismatched++; $display("FAIL en_ramp: got %0d want 2", st(0)); end
      step();
      step();
      tick(); step(); tick(); step();
      compared++;
      if (amp_disable_pin[0] !== 1'b1 || st(0) !== 2'd2) begin mismatched++; $display("FAIL en_two_ticks: got pin=%b st=%0d want 1/2", amp_disable_pin[0], st(0)); end
      tick();
      compared++;
      if (amp_disable_pin !== 4'b1110 || st(0) !== 2'd3) begin mismatched++; $display("FAIL en_third_tick: got pin=%b st=%0d want 1110/3", amp_disable_pin, st(0)); end
      compared++;
      if (cur_cmd[15:0] !== 16'h8000) begin mismatched++; $display("FAIL en_cmd_kept: got %h want 8000", cur_cmd[15:0]); end
      wr(dac_a(1), 32'h2000_0000);
      compared++;
      if (amp_disable_pin[0] !== 1'b1) begin mismatched++; $display("FAIL disable_pin: got %b want 1", amp_disable_pin[0]); end
   endtask

   task automatic test_stagger();
      do_reset();
      pwr_enable = 1'b1;
      wr(cfg_a(1), 32'h0003_8418);
      wr(cfg_a(2), 32'h0003_8418);
      en_pair();
      step();
      step();
      compared++;
      if (st(0) !== 2'd2 || st(1) !== 2'd1) begin mismatched++; $display("FAIL stag_hold: got %0d/%0d want 2/1", st(0), st(1)); end
      tick(); tick(); tick();
      compared++;
      if (amp_disable_pin[1:0] !== 2'b10 || st(1) !== 2'd1) begin mismatched++; $display("FAIL stag_first_on: got pin=%b st1=%0d want 10/1", amp_disable_pin[1:0], st(1)); end
      step();
      compared++;
      if (st(1) !== 2'd2) begin mismatched++; $display("FAIL stag_grant: got %0d want 2", st(1)); end
      tick(); tick();
      compared++;
      if (amp_disable_pin[1] !== 1'b1) begin mismatched++; $display("FAIL stag_early: got %b want 1", amp_disable_pin[1]); end
      tick();
      compared++;
      if (amp_disable_pin[1:0] !== 2'b00) begin mismatched++; $display("FAIL stag_second_on: got %b want 00", amp_disable_pin[1:0]); end
   endtask

   task automatic test_fault();
      do_reset();
      pwr_enable = 1'b1;
      wr(dac_a(1), 32'h3000_0000);
      amp_fault = 4'b1110;
      repeat (15) step();
      amp_fault = 4'hF;
      compared++;
      if (stat(0)[31] !== 1'b0 || stat(0)[28] !== 1'b1) begin mismatched++; $display("FAIL fault_short: got %h want lat=0 en=1", stat(0)); end
      step();
      amp_fault = 4'b1110;
      repeat (15) step();
      compared++;
      if (stat(0)[31] !== 1'b0) begin mismatched++; $display("FAIL fault_pre: got %b want 0", stat(0)[31]); end
      step();
      compared++;
      if (stat(0)[31] !== 1'b1) begin mismatched++; $display("FAIL fault_latch: got %b want 1", stat(0)[31]); end
      amp_fault = 4'hF;
      step();
      compared++;
      if (stat(0)[28] !== 1'b0 || amp_disable_pin[0] !== 1'b1) begin mismatched++; $display("FAIL fault_trip: got en=%b pin=%b want 0/1", stat(0)[28], amp_disable_pin[0]); end
      wr(dac_a(1), 32'h3000_0000);
      compared++;
      if (stat(0)[31] !== 1'b0 || stat(0)[28] !== 1'b0) begin mismatched++; $display("FAIL fault_clear: got lat=%b en=%b want 0/0", stat(0)[31], stat(0)[28]); end
      wr(dac_a(1), 32'h3000_0000);
      compared++;
      if (stat(0)[28] !== 1'b1) begin mismatched++; $display("FAIL fault_reenable: got %b want 1", stat(0)[28]); end
   endtask

   task automatic test_mode();
      do_reset();
      ioexp_present = 1'b0;
      wr(dac_a(1), 32'h8000_5678);
      compared++;
      if (cur_cmd[15:0] !== 16'h5678) begin mismatched++; $display("FAIL mode0_cmd: got %h want 5678", cur_cmd[15:0]); end
      wr(dac_a(1), 32'h8100_1234);
      compared++;
      if (cur_cmd[15:0] !== 16'h5678 || ctrl_mode[3:0] !== 4'd0 || cur_ctrl[0] !== 1'b1) begin
         mismatched++; $display("FAIL mode1_noexp: got cmd=%h mode=%h cc=%b want 5678/0/1", cur_cmd[15:0], ctrl_mode[3:0], cur_ctrl[0]);
      end
      ioexp_present = 1'b1;
      wr(dac_a(1), 32'h8200_4321);
      compared++;
      if (cur_cmd[15:0] !== 16'h5678) begin mismatched++; $display("FAIL mode2_reject: got %h want 5678", cur_cmd[15:0]); end
      wr(dac_a(1), 32'h8100_1234);
      compared++;
      if (cur_cmd[15:0] !== 16'h1234 || ctrl_mode[3:0] !== 4'd1 || cur_ctrl[0] !== 1'b0 || safety_en[0] !== 1'b0) begin
         mismatched++; $display("FAIL mode1_exp: got cmd=%h mode=%h cc=%b se=%b want 1234/1/0/0", cur_cmd[15:0], ctrl_mode[3:0], cur_ctrl[0], safety_en[0]);
      end
   endtask

   task automatic test_trip_mid_ramp();
      do_reset();
      pwr_enable = 1'b1;
      en_pair();
      step();
      step();
      tick();
      safety_trip = 4'b0001;
      #1;
      compared++;
      if (stat(0)[17] !== 1'b1) begin mismatched++; $display("FAIL trip_status: got %b want 1", stat(0)[17]); end
      @(posedge clk);
      #1;
      safety_trip = 4'b0000;
      compared++;
      if (amp_disable_pin[0] !== 1'b1 || st(0) !== 2'd2) begin mismatched++; $display("FAIL trip_pin: got pin=%b st=%0d want 1/2", amp_disable_pin[0], st(0)); end
      step();
      compared++;
      if (st(0) !== 2'd0 || st(1) !== 2'd1) begin mismatched++; $display("FAIL trip_off: got %0d/%0d want 0/1", st(0), st(1)); end
      step();
      compared++;
      if (st(1) !== 2'd2) begin mismatched++; $display("FAIL trip_regrant: got %0d want 2", st(1)); end
      wdog_timeout = 1'b1;
      step();
      wdog_timeout = 1'b0;
      compared++;
      if (amp_disable_pin[1] !== 1'b1 || st(1) !== 2'd2 || stat(1)[28] !== 1'b0) begin
         mismatched++; $display("FAIL wdog_pin: got pin=%b st=%0d en=%b want 1/2/0", amp_disable_pin[1], st(1), stat(1)[28]);
      end
      step();
      compared++;
      if (st(1) !== 2'd0 || amp_disable_pin !== 4'hF) begin mismatched++; $display("FAIL wdog_off: got st=%0d pin=%h want 0/f", st(1), amp_disable_pin); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      pwr_enable = 1'b1;
      wr(cfg_a(1), 32'h0000_8418);
      wr(dac_a(1), 32'h3000_0000);
      step();
      step();
      compared++;
      if (st(0) !== 2'd2) begin mismatched++; $display("FAIL zero_ramp: got %0d want 2", st(0)); end
      step();
      compared++;
      if (st(0) !== 2'd3 || amp_disable_pin[0] !== 1'b0) begin mismatched++; $display("FAIL zero_on: got st=%0d pin=%b want 3/0", st(0), amp_disable_pin[0]); end
      wr(dac_a(2), 32'h3000_0000);
      step();
      step();
      compared++;
      if (st(1) !== 2'd2) begin mismatched++; $display("FAIL rst_pre: got %0d want 2", st(1)); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      compared++;
      if (st(0) !== 2'd0 || st(1) !== 2'd0 || amp_disable_pin !== 4'hF) begin
         mismatched++; $display("FAIL rst_mid_ramp: got st=%0d/%0d pin=%h want 0/0/f", st(0), st(1), amp_disable_pin);
      end
   endtask

   initial begin
      test_reset();
      test_enable_delay();
      test_stagger();
      test_fault();
      test_mode();
      test_trip_mid_ramp();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/motor_channel_bank.md
# motor_channel_bank

Parametrised bank of NUM_CHAN QLA-style motor channels sharing one register write bus, one clock and one synchronous reset. Per channel it holds the current/voltage command, control mode, amplifier enable, delay and current-limit configuration. Beyond the per-channel logic it adds a staggered power-up sequencer that lets only one amplifier at a time go through its enable delay. It also adds a filtered, latched amplifier-fault trip. The block sits between the register decoder and the DAC, I/O-expander and amplifier pins, and replaces per-channel instances.

## Interface
- NUM_CHAN, 4: number of channels, 1..15; channel i (0-based) uses register channel field i+1.
- STAGGER, 1: 1 means at most one channel in RAMP at a time; 0 means every channel ramps independently.
- DEFAULT_DELAY, 8'd120: reset value of every delay_cnt (120 ticks = 2.5 ms at 48 kHz).
- DEFAULT_LIM, 16'h8418: reset value of every cur_lim (200 mA).
- FAULT_FILT, 16: number of consecutive clk cycles of asserted fault needed to latch a trip, 1..255.
- clk  in  1  system clock, 49.152 MHz.
- reset  in  1  synchronous, active-high.
- delay_tick  in  1  one-clk pulse at 48 kHz; the delay timebase.
- reg_waddr  in  16  write address.
- reg_wdata  in  32  write data.
- reg_wen  in  1  write strobe.
- ioexp_present  in  1  high means QLA 1.5+ (voltage mode available, enable delay active).
- pwr_enable  in  1  board power enable state.
- pwr_enable_cmd  in  1  host is enabling board power.
- mv_amp_disable  in  1  temporary global amplifier disable.
- wdog_timeout  in  1  watchdog timeout.
- amp_fault  in  NUM_CHAN  active low; 1 means the amplifier is on.
- safety_trip  in  NUM_CHAN  per-channel trip from the external SafetyCheck.
- cur_cmd  out  16*NUM_CHAN  commands; channel i occupies [16i+15:16i].
- ctrl_mode  out  4*NUM_CHAN  control modes.
- cur_ctrl  out  NUM_CHAN  1 = current control.
- cur_lim  out  16*NUM_CHAN  current limits.
- safety_en  out  NUM_CHAN  enable_check for the SafetyCheck = ~disable_safety & cur_ctrl.
- clr_safety  out  NUM_CHAN  = pwr_enable_cmd | amp_enable_cmd[i].
- amp_enable_cmd  out  NUM_CHAN  host enable command strobe.
- amp_disable_pin  out  NUM_CHAN  amplifier disable pin.
- amp_disable_f  out  NUM_CHAN  follower op-amp disable.
- motor_status  out  32*NUM_CHAN  per-channel status word.
- motor_config  out  32*NUM_CHAN  per-channel configuration word.

## Operation
- Address decode:
  - dac_wen[i] is asserted when reg_waddr == {`ADDR_MAIN, 4'd0, i+1, `OFF_DAC_CTRL} and reg_wen is high.
  - cfg_wen[i] is asserted when reg_waddr == {`ADDR_MAIN, 4'd0, i+1, `OFF_MOTOR_CONFIG} and reg_wen is high.
  - amp_enable_cmd[i] = dac_wen[i] & wdata[29] & wdata[28].
- DAC write:
  - If wdata[31] is set and the mode is valid (wdata[27:24]==0, or ==1 with ioexp_present), load cur_cmd from wdata[15:0] and ctrl_mode from wdata[27:24].
  - reg_disable <= ~pwr_enable | sdis | (wdata[29] ? ~wdata[28] : reg_disable).
  - sdis = wdog_timeout | safety_trip[i] | fault_lat[i].
- Config write: disable_safety <= wdata[31], force_disable_f <= wdata[30], delay_cnt <= wdata[23:16], cur_lim <= wdata[15:0].
- With no write, reg_disable <= reg_disable | sdis.
- Combinational outputs:
  - cur_ctrl = ~(ioexp_present & ctrl_mode==1).
  - amp_dis = reg_disable | mv_amp_disable.
  - amp_disable_f = ~force_disable_f & amp_dis.
- Fault filter:
  - The filter counter increments while ~amp_dis & ~amp_fault, and clears otherwise.
  - When it reaches FAULT_FILT, fault_lat is set.
  - fault_lat is cleared only by amp_enable_cmd[i], reset, or pwr_enable_cmd.
- Sequencer, per channel: OFF(0), WAIT(1), RAMP(2), ON(3).
  - OFF goes to WAIT when amp_dis is 0. If ioexp_present is 0, OFF goes directly to ON.
  - WAIT goes to RAMP on grant. The grant goes to the lowest-index waiting channel when no channel is in RAMP (STAGGER=1), and is always given when STAGGER=0.
  - On entering RAMP the channel's tick counter clears.
  - In RAMP the counter increments on each delay_tick. When counter == delay_cnt the channel goes to ON.
  - Any state goes to OFF when amp_dis is 1; this has priority over every other transition.
- amp_disable_pin = amp_dis | (ioexp_present & state != ON).
- Status word:
  - [31] fault_lat
  - [30] 0
  - [29] amp_fault
  - [28] ~reg_disable
  - [27:24] ctrl_mode
  - [23:22] state
  - [21] 0
  - [20] cur_ctrl
  - [19:18] 0
  - [17] safety_trip
  - [16] ~(amp_dis | amp_fault)
  - [15:0] cur_cmd
- Config word: {disable_safety, force_disable_f, 4'd0, ioexp_present, 1'b1, delay_cnt, cur_lim}.
- Reset values:
  - cur_cmd = 16'h8000, ctrl_mode = 0, reg_disable = 1.
  - delay_cnt = DEFAULT_DELAY, cur_lim = DEFAULT_LIM.
  - disable_safety = 0, force_disable_f = 0.
  - fault_lat = 0, state = OFF.
  - Resulting outputs: amp_disable_pin all 1, amp_disable_f all 1.

## Timing
- Register writes take effect on the clk edge after reg_wen; the outputs derived from them update in the same cycle the register updates.
- Disable path: amp_dis to amp_disable_pin is combinational, with zero-cycle latency.
- Enable latency with ioexp_present and an idle slot:
  - cycle 0: reg_disable falls.
  - cycle 1: state = WAIT.
  - cycle 2: state = RAMP.
  - The pin goes low the cycle after the delay_cnt-th tick counted in RAMP.
- delay_cnt = 0: RAMP goes to ON on the next clk without waiting for a tick.
- When a RAMP channel reaches ON, the next WAIT channel is granted in the following cycle.
- A disable mid-RAMP releases the slot the next cycle.
- Simultaneous DAC and config writes cannot occur (one address). A trip arriving in the same cycle as an enable write wins, and reg_disable stays 1.
- Writing delay_cnt mid-RAMP: the comparison uses the new value. If the counter already exceeds it, the counter keeps incrementing and wraps modulo 256 until equality.
- Reset mid-RAMP returns every channel to OFF in one cycle.

## Test plan
- Reset, then idle: all amp_disable_pin = 1, each cur_cmd = 16'h8000, motor_config[0] = 32'h0378_8418 with ioexp_present = 1.
- With pwr_enable = 1 and ioexp_present = 1, write DAC ch1 wdata = 32'h3000_0000 at delay_cnt = 3: the pin goes low exactly one clk after the 3rd delay_tick counted in RAMP.
- STAGGER = 1: enable ch1 and ch2 in consecutive cycles → ch2 stays in WAIT (status[23:22] = 1) until ch1 reaches ON, then ramps; the two pin falls are at least 3 ticks apart.
- Hold amp_fault[0] = 0 while enabled for FAULT_FILT-1 cycles → no trip. Hold it for FAULT_FILT cycles → status[31] = 1, reg_disable = 1, pin = 1. A subsequent enable write clears the latch.
- Write ctrl_mode = 1 with ioexp_present = 0 and wdata[31] = 1 → cur_cmd and ctrl_mode are unchanged and cur_ctrl = 1. The same write with ioexp_present = 1 gives cur_ctrl = 0 and safety_en = 0.
- Assert wdog_timeout mid-RAMP → the pin stays 1, the state goes to OFF next cycle, and the WAIT channel is granted the cycle after.
